// File: rtl/divider_if.sv
// divider_if: start/operand/result bundle between execute-stage control and the divider.
interface divider_if;
  logic        start, signed_div, cancel, busy, done;
  logic [31:0] dividend, divisor, quotient, remainder;
  modport master (output start, signed_div, dividend, divisor, cancel, input busy, done, quotient, remainder);
  modport slave  (input start, signed_div, dividend, divisor, cancel, output busy, done, quotient, remainder);
endinterface

// File: rtl/divider.sv
// divider: iterative radix-2 restoring 32-bit DIV/DIVU divider, 33-cycle latency.
// DIVIDER_EARLY_OUT_EN: divide-by-zero and |dividend| < |divisor| finish in one cycle.
module divider (
  input logic clk,
  input logic rst,
  divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] r, q, dvs, dvd, a_mag, b_mag, q_nx, r_nx, q_fin, r_fin, quotient, remainder;
  logic [32:0] part, diff;
  logic        sq, sr, zero, accept, early;
  assign a_mag  = (bus.signed_div & bus.dividend[31]) ? -bus.dividend : bus.dividend;
  assign b_mag  = (bus.signed_div & bus.divisor[31]) ? -bus.divisor : bus.divisor;
  assign accept = state == IDLE & bus.start & ~bus.cancel;
`ifdef DIVIDER_EARLY_OUT_EN
  assign early  = bus.divisor == 32'd0 || a_mag < b_mag;
`else
  assign early  = 1'b0;
`endif
  assign part  = {r, q[31]};
  assign diff  = part - {1'b0, dvs};
  assign r_nx  = diff[32] ? part[31:0] : diff[31:0];
  assign q_nx  = {q[30:0], ~diff[32]};
  // divide-by-zero bypasses sign correction: all-ones quotient, raw dividend
  assign q_fin = zero ? '1 : sq ? -q_nx : q_nx;
  assign r_fin = zero ? dvd : sr ? -r_nx : r_nx;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  always_comb
    state_nx = bus.cancel ? IDLE :
               state == IDLE ? (bus.start ? (early ? DONE : CALC) : IDLE) :
               state == CALC ? (cnt == 6'd31 ? DONE : CALC) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      r <= '0;
      q <= '0;
      dvs <= '0;
      dvd <= '0;
      sq <= 1'b0;
      sr <= 1'b0;
      zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt <= '0;
      r <= '0;
      q <= a_mag;
      dvs <= b_mag;
      dvd <= bus.dividend;
      sq <= bus.signed_div & (bus.dividend[31] ^ bus.divisor[31]);
      sr <= bus.signed_div & bus.dividend[31];
      zero <= bus.divisor == 32'd0;
      if (early) begin
        quotient <= bus.divisor == 32'd0 ? '1 : '0;
        remainder <= bus.dividend;
      end
    end else if (state == CALC && !bus.cancel) begin
      cnt <= cnt + 6'd1;
      r <= r_nx;
      q <= q_nx;
      if (cnt == 6'd31) begin
        quotient <= q_fin;
        remainder <= r_fin;
      end
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed-vector self-checking bench for divider (honours DIVIDER_EARLY_OUT_EN).
module tb_divider;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_err = 0;
  divider_if bus ();
  divider u_dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(string tag, logic sd, logic [31:0] a, logic [31:0] b,
                     logic [31:0] eq, logic [31:0] er, int lat, bit poke);
    int first, cnt;
    first = 0;
    cnt = 0;
    bus.start = 1'b1;
    bus.signed_div = sd;
    bus.dividend = a;
    bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, " busy_t1"}, {31'b0, bus.busy}, 32'd1);
    for (int n = 1; n <= lat + 2; n++) begin
      if (bus.done) begin
        cnt++;
        if (first == 0) first = n;
      end
      if (poke) begin
        bus.start = (n == 4);
        bus.dividend = 32'h0000dead;
        bus.divisor = 32'd1;
      end
      if (n == lat + 1) chk({tag, " busy_after"}, {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
    end
    chk({tag, " latency"}, first, lat);
    chk({tag, " done_count"}, cnt, 32'd1);
    chk({tag, " quotient"}, bus.quotient, eq);
    chk({tag, " remainder"}, bus.remainder, er);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset quotient", bus.quotient, 32'd0);
    chk("reset remainder", bus.remainder, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run("divu 100/7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 33, 1'b0);
    run("div -100/7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 33, 1'b0);
    run("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33, 1'b0);
    run("divu by0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, EL, 1'b0);
    run("divu 5/9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, EL, 1'b0);
    run("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 1'b0);
    run("div -7/0", 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, EL, 1'b0);
    // start and cancel together: nothing accepted
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    chk("start+cancel busy", {31'b0, bus.busy}, 32'd0);
    // cancel in T+10
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel busy", {31'b0, bus.busy}, 32'd0);
    chk("cancel done", {31'b0, bus.done}, 32'd0);
    chk("cancel quotient hold", bus.quotient, 32'hFFFFFFFF);
    chk("cancel remainder hold", bus.remainder, 32'hFFFFFFF9);
    run("after cancel 1000/3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 1'b1);
    // asynchronous reset mid-CALC
    bus.start = 1'b1;
    bus.dividend = 32'd99;
    bus.divisor = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", {31'b0, bus.busy}, 32'd0);
    chk("arst done", {31'b0, bus.done}, 32'd0);
    chk("arst quotient", bus.quotient, 32'd0);
    chk("arst remainder", bus.remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("post reset 99/4", 1'b0, 32'd99, 32'd4, 32'd24, 32'd3, 33, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
